seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
- Parametrised successor of the fixed A-B-B-C recogniser: detects a programmable sequence of LEN symbols, each SYM_W bits wide, in a stream of valid-qualified symbols.
- Adds a runtime-loadable pattern with per-position don't-care mask, an overlap/non-overlap mode and a saturating match counter.
- Sits between a symbol source (encoder/test stimulus) and any consumer of the match pulse.

Parameters:
- SYM_W, 2, symbol width in bits; A=0, B=1, C=3 under the default.
- LEN, 4, pattern length in symbols, minimum 1.
- CNT_W, 8, match counter width.
- RST_PAT, {2'd3,2'd1,2'd1,2'd0}, pattern loaded at reset, LEN*SYM_W bits; position 0 (first symbol of sequence) in the LSBs. Default is A,B,B,C.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_sym is sampled on this edge.
- in_sym  in  SYM_W  input symbol.
- overlap  in  1  1 = overlapping matches allowed; 0 = history flushed after a match.
- cfg_we  in  1  pattern write strobe.
- cfg_idx  in  $clog2(LEN) (min 1)  pattern position to write.
- cfg_sym  in  SYM_W  symbol for that position.
- cfg_care  in  1  1 = compare this position; 0 = don't-care.
- clr_cnt  in  1  synchronous clear of match_count.
- out  out  1  match pulse, one clock wide.
- match_count  out  CNT_W  number of matches, saturating.
- fill  out  $clog2(LEN+1)  valid symbols in history, for debug.

Behaviour:
- Reset (reset_n low, asynchronous): out=0, match_count=0, fill=0, history=0, pattern=RST_PAT, all care bits=1.
- History: shift register of the last LEN accepted symbols. A symbol is accepted only on an edge with in_valid=1.
- fill counter states:
  - EMPTY: fill=0.
  - FILLING: 0<fill<LEN.
  - FULL: fill=LEN.
  - fill increments on acceptance and saturates at LEN.
- Match condition is evaluated on an accepting edge, over the new symbol plus the previous LEN-1 history entries:
  - (fill+1 >= LEN), and
  - for every position with care=1, window symbol equals the pattern symbol.
- out is registered. It is 1 for exactly the cycle after the accepting edge that completes a match; otherwise 0. Latency is 1 clock. An edge with in_valid=0 always drives out=0.
- After a match:
  - overlap=1: history kept; fill stays at LEN.
  - overlap=0: fill forced to 0 on the same edge. The next match needs LEN fresh symbols.
- match_count increments on every match and saturates at 2^CNT_W-1 (no wrap).
  - clr_cnt has priority over an increment on the same edge; the result is 0.
- cfg_we: pattern[cfg_idx] and care[cfg_idx] are written on the edge.
  - The same edge also flushes fill to 0.
  - Any symbol accepted on that edge is discarded and cannot produce a match.
  - cfg_idx >= LEN: write ignored, no flush.
- All care bits 0: every accepting edge with fill+1 >= LEN matches.
- Reset asserted mid-sequence: partial history is lost immediately and the pattern reverts to RST_PAT.
- LEN=1: the window is the current symbol only. fill toggles between 0 and 1 when overlap=0.

Decomposition:
- Shared package seq_pkg holds:
  - symbol encodings SYM_A=0, SYM_B=1, SYM_C=3;
  - default pattern constant;
  - the fill-state localparams EMPTY/FILLING/FULL.
- One natural sub-module, seq_window_cmp: combinational masked comparator of the LEN-symbol window against pattern/care, producing a 1-bit hit. The top level keeps history, fill, counter and the config registers.

Test Plan:
1. Defaults after reset, overlap=0, stream A,B,C,A,B,B,C with in_valid=1 every clock -> out high exactly once, the cycle after the final C is sampled; match_count=1; fill=0.
2. overlap=1, pattern written to A,A,A (LEN=3, all care), stream A×5 -> out high on the 3rd, 4th and 5th accepting edges; match_count=3. Same stream with overlap=0 -> one match, on the 3rd edge only.
3. Default pattern, stream A,B,B,C with in_valid deasserted for 2 clocks between the two Bs -> still exactly one match; out never high on the idle cycles.
4. cfg_we to idx 1 with cfg_care=0, stream A,C,B,C -> match. Then cfg_we asserted while the 4th symbol is valid -> no match on that edge; fill=0 afterwards.
5. CNT_W=2, repeated matches -> match_count goes 1,2,3,3. clr_cnt together with a match -> match_count=0.
6. reset_n pulsed low asynchronously after A,B,B -> out, match_count and fill are 0 immediately. A following C alone gives no match; a full A,B,B,C does.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared encodings and helpers for the parametrised sequence detector.
package seq_pkg;

  localparam logic [1:0] SYM_A = 2'd0;
  localparam logic [1:0] SYM_B = 2'd1;
  localparam logic [1:0] SYM_C = 2'd3;

  // Default pattern A,B,B,C with position 0 in the LSBs.
  localparam logic [7:0] DEF_PAT = {SYM_C, SYM_B, SYM_B, SYM_A};

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] FILLING = 2'd1;
  localparam logic [1:0] FULL    = 2'd2;

  function automatic logic [1:0] fill_state(input int unsigned fill, input int unsigned len);
    if (fill == 0)
      return EMPTY;
    else if (fill >= len)
      return FULL;
    else
      return FILLING;
  endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// Masked compare of the symbol window against the programmed pattern.
module seq_window_cmp #(
  parameter int SYM_W = 2,
  parameter int LEN   = 4
) (
  input  logic [LEN*SYM_W-1:0] window,
  input  logic [LEN*SYM_W-1:0] pattern,
  input  logic [LEN-1:0]       care,
  output logic                 hit
);

  always_comb begin
    hit = 1'b1;
    for (int i = 0; i < LEN; i++) begin
      if (care[i] && (window[i*SYM_W +: SYM_W] != pattern[i*SYM_W +: SYM_W]))
        hit = 1'b0;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Programmable sequence detector: history, fill tracking, pattern registers
// and a saturating match counter around a masked window comparator.
module seq_detector_param
  import seq_pkg::*;
#(
  parameter int                   SYM_W   = 2,
  parameter int                   LEN     = 4,
  parameter int                   CNT_W   = 8,
  parameter logic [LEN*SYM_W-1:0] RST_PAT = DEF_PAT,
  localparam int                  IDX_W   = (LEN > 1) ? $clog2(LEN) : 1,
  localparam int                  FILL_W  = $clog2(LEN + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [SYM_W-1:0]  in_sym,
  input  logic              overlap,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [SYM_W-1:0]  cfg_sym,
  input  logic              cfg_care,
  input  logic              clr_cnt,
  output logic              out,
  output logic [CNT_W-1:0]  match_count,
  output logic [FILL_W-1:0] fill
);

  localparam logic [FILL_W:0]   LEN_CMP   = (FILL_W + 1)'(LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);
  localparam logic [IDX_W:0]    LEN_IDX   = (IDX_W + 1)'(LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [LEN*SYM_W-1:0] hist;
  logic [LEN*SYM_W-1:0] pattern;
  logic [LEN-1:0]       care;
  logic [LEN*SYM_W-1:0] window;
  logic                 hit;
  logic                 cfg_wr;
  logic                 enough;
  logic                 match;

  // Window is the incoming symbol on top of the newest LEN-1 history entries.
  generate
    if (LEN == 1) begin : g_len1
      assign window = in_sym;
    end else begin : g_lenn
      assign window = {in_sym, hist[LEN*SYM_W-1:SYM_W]};
    end
  endgenerate

  seq_window_cmp #(
    .SYM_W (SYM_W),
    .LEN   (LEN)
  ) u_cmp (
    .window  (window),
    .pattern (pattern),
    .care    (care),
    .hit     (hit)
  );

  assign cfg_wr = cfg_we && ({1'b0, cfg_idx} < LEN_IDX);
  assign enough = ({1'b0, fill} + (FILL_W + 1)'(1)) >= LEN_CMP;
  // A config write discards whatever symbol arrives on the same edge.
  assign match  = in_valid && !cfg_wr && enough && hit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out         <= 1'b0;
      match_count <= '0;
      fill        <= '0;
      hist        <= '0;
      pattern     <= RST_PAT;
      care        <= '1;
    end else begin
      out <= match;

      if (cfg_wr) begin
        pattern[cfg_idx*SYM_W +: SYM_W] <= cfg_sym;
        care[cfg_idx]                   <= cfg_care;
        fill                            <= '0;
      end else if (in_valid) begin
        hist <= window;
        if (match)
          fill <= overlap ? FILL_FULL : '0;
        else if (fill_state(int'(fill), LEN) != FULL)
          fill <= fill + FILL_W'(1);
      end

      if (clr_cnt)
        match_count <= '0;
      else if (match && (match_count != CNT_MAX))
        match_count <= match_count + CNT_W'(1);
    end
  end

endmodule
